huff_lut_build: RTL and testbench



---
 rtl/huff_lut_build.sv | 192 +++++++++++++++++++
 tb/tb_huff_lut_build.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/huff_lut_build.sv
// Canonical-Huffman decode-table builder: scans code lengths shortest-first, assigns
// canonical codes and writes each code replicated over every table slot sharing its prefix.
module huff_lut_build #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int SYM_W   = 9,
    parameter int ADDR_W  = 9,
    parameter int REVERSE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [SYM_W-1:0]  sym_num,
    input  logic [ADDR_W-1:0] len_base,
    output logic [ADDR_W-1:0] len_addr,
    input  logic [LEN_W-1:0]  len_data,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [MAX_LEN-1:0] wr_addr,
    output logic [SYM_W-1:0]  wr_sym,
    output logic [LEN_W-1:0]  wr_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              incomplete
);

    localparam int CW = MAX_LEN + 1;
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [CW-1:0]    FULL  = CW'(1) << MAX_LEN;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CHECK, S_FILL, S_DONE} state_t;

    state_t              r_state;
    logic [SYM_W-1:0]    r_sym_num;
    logic [ADDR_W-1:0]   r_base;
    logic [LEN_W-1:0]    r_len;
    logic [SYM_W-1:0]    r_i;
    logic [CW-1:0]       r_code;
    logic [MAX_LEN-1:0]  r_fill;
    logic [ADDR_W-1:0]   r_len_addr;
    logic                r_wr_en;
    logic [MAX_LEN-1:0]  r_wr_addr;
    logic [SYM_W-1:0]    r_wr_sym;
    logic [LEN_W-1:0]    r_wr_len;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_incomplete;

    logic [SYM_W:0]      w_i_inc;
    logic                w_more_sym;
    logic [CW-1:0]       w_code_adv;
    logic [MAX_LEN-1:0]  w_fill_max;
    logic                w_fill_last;
    logic                w_len_bad;
    logic                w_len_hit;
    logic                w_full_l;
    logic                w_advance;

    // Table index = code left-justified into MAX_LEN bits with the fill counter as the low bits.
    function automatic logic [MAX_LEN-1:0] f_addr(input logic [CW-1:0] code,
                                                  input logic [LEN_W-1:0] len,
                                                  input logic [MAX_LEN-1:0] fill);
        logic [MAX_LEN-1:0] v_idx;
        logic [MAX_LEN-1:0] v_rev;
        v_idx = MAX_LEN'(code << (MAX_L - len)) | fill;
        for (int b = 0; b < MAX_LEN; b++) begin
            v_rev[b] = v_idx[MAX_LEN-1-b];
        end
        return (REVERSE != 0) ? v_rev : v_idx;
    endfunction

    always_comb begin
        w_i_inc     = {1'b0, r_i} + 1'b1;
        w_more_sym  = w_i_inc < {1'b0, r_sym_num};
        w_code_adv  = (r_state == S_FILL) ? r_code + 1'b1 : r_code;
        w_fill_max  = MAX_LEN'((CW'(1) << (MAX_L - r_len)) - CW'(1));
        w_fill_last = (r_fill == w_fill_max);
        w_len_bad   = (len_data > MAX_L);
        w_len_hit   = (len_data == r_len);
        w_full_l    = (r_code == (CW'(1) << r_len));
        // Move to the next symbol after a non-matching check or the final write beat.
        w_advance   = ((r_state == S_CHECK) && !w_len_bad && !w_len_hit) ||
                      ((r_state == S_FILL) && wr_ready && w_fill_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_sym_num    <= '0;
            r_base       <= '0;
            r_len        <= LEN_W'(1);
            r_i          <= '0;
            r_code       <= '0;
            r_fill       <= '0;
            r_len_addr   <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_sym     <= '0;
            r_wr_len     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_incomplete <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_advance) begin
                r_wr_en <= 1'b0;
                if (w_more_sym) begin
                    r_i        <= r_i + 1'b1;
                    r_len_addr <= r_base + ADDR_W'(w_i_inc);
                    r_code     <= w_code_adv;
                    r_state    <= S_FETCH;
                end else if (r_len != MAX_L) begin
                    r_code     <= w_code_adv << 1;
                    r_len      <= r_len + 1'b1;
                    r_i        <= '0;
                    r_len_addr <= r_base;
                    r_state    <= S_FETCH;
                end else begin
                    r_code       <= w_code_adv;
                    r_incomplete <= (w_code_adv != FULL);
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_sym_num <= sym_num;
                            r_base    <= len_base;
                            r_len     <= LEN_W'(1);
                            r_i       <= '0;
                            r_code    <= '0;
                            r_fill    <= '0;
                            r_err     <= 1'b0;
                            r_busy    <= 1'b1;
                            if (sym_num == '0) begin
                                r_incomplete <= 1'b1;
                                r_done       <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_incomplete <= 1'b0;
                                r_len_addr   <= len_base;
                                r_state      <= S_FETCH;
                            end
                        end
                    end
                    S_FETCH: r_state <= S_CHECK;
                    S_CHECK: begin
                        // Not advancing here means the length is illegal or matches L.
                        if (w_len_bad || w_full_l) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_fill    <= '0;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= f_addr(r_code, r_len, '0);
                            r_wr_sym  <= r_i;
                            r_wr_len  <= r_len;
                            r_state   <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (wr_ready) begin
                            r_fill    <= r_fill + 1'b1;
                            r_wr_addr <= f_addr(r_code, r_len, r_fill + 1'b1);
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign len_addr   = r_len_addr;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_sym     = r_wr_sym;
    assign wr_len     = r_wr_len;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign incomplete = r_incomplete;

endmodule

// File: tb/tb_huff_lut_build.sv
// Directed bench for huff_lut_build: MSB-first and bit-reversed instances run side by side
// on MAX_LEN=4 length sets with hand-derived decode tables.
module tb_huff_lut_build;

    logic       clk = 1'b0;
    logic       rst_n, start, wr_ready, clr;
    logic [8:0] sym_num, len_base;
    logic [8:0] len_addr0, len_addr1;
    logic [3:0] len_data0, len_data1;
    logic       wr_en0, wr_en1;
    logic [3:0] wr_addr0, wr_addr1;
    logic [8:0] wr_sym0, wr_sym1;
    logic [3:0] wr_len0, wr_len1;
    logic       busy0, busy1, done0, done1, err0, err1, inc0, inc1;

    logic [3:0] mem [512];
    int hits0 [16], hits1 [16], tsym0 [16], tsym1 [16], tlen0 [16], tlen1 [16];
    int wcnt0, wcnt1, dcnt0;
    int en [16], er [16], lv [8];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    huff_lut_build #(.MAX_LEN(4), .LEN_W(4), .SYM_W(9), .ADDR_W(9), .REVERSE(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sym_num(sym_num), .len_base(len_base),
        .len_addr(len_addr0), .len_data(len_data0), .wr_en(wr_en0), .wr_ready(wr_ready),
        .wr_addr(wr_addr0), .wr_sym(wr_sym0), .wr_len(wr_len0), .busy(busy0), .done(done0),
        .err(err0), .incomplete(inc0));

    huff_lut_build #(.MAX_LEN(4), .LEN_W(4), .SYM_W(9), .ADDR_W(9), .REVERSE(1)) u_dut_rev (
        .clk(clk), .rst_n(rst_n), .start(start), .sym_num(sym_num), .len_base(len_base),
        .len_addr(len_addr1), .len_data(len_data1), .wr_en(wr_en1), .wr_ready(wr_ready),
        .wr_addr(wr_addr1), .wr_sym(wr_sym1), .wr_len(wr_len1), .busy(busy1), .done(done1),
        .err(err1), .incomplete(inc1));

    always @(posedge clk) begin
        len_data0 <= mem[len_addr0];
        len_data1 <= mem[len_addr1];
    end

    // Record accepted write beats; a beat is taken at the next rising edge.
    always @(negedge clk) begin
        if (clr) begin
            for (int a = 0; a < 16; a++) begin
                hits0[a] = 0; hits1[a] = 0; tsym0[a] = 0; tsym1[a] = 0; tlen0[a] = 0; tlen1[a] = 0;
            end
            wcnt0 = 0; wcnt1 = 0; dcnt0 = 0;
        end else begin
            if (wr_en0 && wr_ready) begin
                hits0[wr_addr0] += 1; tsym0[wr_addr0] = int'(wr_sym0); tlen0[wr_addr0] = int'(wr_len0);
                wcnt0++;
            end
            if (wr_en1 && wr_ready) begin
                hits1[wr_addr1] += 1; tsym1[wr_addr1] = int'(wr_sym1); tlen1[wr_addr1] = int'(wr_len1);
                wcnt1++;
            end
            if (done0) dcnt0++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_lens(input logic [8:0] base, input int n);
        for (int k = 0; k < n; k++) mem[9'(int'(base) + k)] = 4'(lv[k]);
    endtask

    task automatic run_case(input int n, input logic [8:0] base, input bit bp, input bit extra,
                            output int lat);
        logic       stl;
        logic [3:0] paddr;
        logic [8:0] psym;
        set_lens(base, n);
        clr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        clr = 1'b0;
        sym_num = 9'(n); len_base = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; stl = 1'b0; paddr = '0; psym = '0;
        forever begin
            @(negedge clk);
            if (stl) begin
                chk("stall_en", 32'(wr_en0), 32'd1);
                chk("stall_addr", 32'(wr_addr0), 32'(paddr));
                chk("stall_sym", 32'(wr_sym0), 32'(psym));
            end
            stl = wr_en0 && !wr_ready; paddr = wr_addr0; psym = wr_sym0;
            if (done0) break;
            lat++;
            if (lat > 3000) begin
                chk("done_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge clk); #1;
            if (bp) wr_ready = ~wr_ready;
            start = extra && (lat == 3);
        end
        wr_ready = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_case(input string nm, input int exp_w, input bit exp_e, input bit exp_i,
                              input int exp_lat, input int lat);
        chk({nm, " err"}, 32'(err0), 32'(exp_e));
        chk({nm, " err_rev"}, 32'(err1), 32'(exp_e));
        chk({nm, " incomplete"}, 32'(inc0), 32'(exp_i));
        chk({nm, " incomplete_rev"}, 32'(inc1), 32'(exp_i));
        chk({nm, " writes"}, 32'(wcnt0), 32'(exp_w));
        chk({nm, " writes_rev"}, 32'(wcnt1), 32'(exp_w));
        chk({nm, " done_pulses"}, 32'(dcnt0), 32'd1);
        chk({nm, " busy_after"}, 32'(busy0), 32'd0);
        if (exp_lat >= 0) chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        for (int a = 0; a < 16; a++) begin
            if (en[a] < 0) chk($sformatf("%s a%0d hits", nm, a), 32'(hits0[a]), 32'd0);
            else begin
                chk($sformatf("%s a%0d hits", nm, a), 32'(hits0[a]), 32'd1);
                chk($sformatf("%s a%0d sym", nm, a), 32'(tsym0[a]), 32'(en[a]));
                chk($sformatf("%s a%0d len", nm, a), 32'(tlen0[a]), 32'(lv[en[a]]));
            end
            if (er[a] < 0) chk($sformatf("%s r%0d hits", nm, a), 32'(hits1[a]), 32'd0);
            else begin
                chk($sformatf("%s r%0d hits", nm, a), 32'(hits1[a]), 32'd1);
                chk($sformatf("%s r%0d sym", nm, a), 32'(tsym1[a]), 32'(er[a]));
                chk($sformatf("%s r%0d len", nm, a), 32'(tlen1[a]), 32'(lv[er[a]]));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, w;
        rst_n = 1'b1; start = 1'b0; wr_ready = 1'b1; clr = 1'b1;
        sym_num = '0; len_base = '0;
        for (int a = 0; a < 512; a++) mem[a] = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst wr_en", 32'(wr_en0), 32'd0);
        chk("rst busy", 32'(busy0), 32'd0);
        chk("rst done", 32'(done0), 32'd0);
        chk("rst len_addr", 32'(len_addr0), 32'd0);
        chk("rst wr_addr", 32'(wr_addr0), 32'd0);
        chk("rst err", 32'(err0), 32'd0);
        chk("rst incomplete", 32'(inc0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // {2,1,3,3} at a wrapping buffer base
        lv = '{2, 1, 3, 3, 0, 0, 0, 0};
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 2, 2, 3, 3};
        er = '{1, 0, 1, 2, 1, 0, 1, 3, 1, 0, 1, 2, 1, 0, 1, 3};
        run_case(4, 9'd510, 1'b0, 1'b0, lat);
        check_case("s1", 16, 1'b0, 1'b0, 48, lat);

        // {1,1,1}: over-subscribed on the third symbol
        lv = '{1, 1, 1, 0, 0, 0, 0, 0};
        en = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        er = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        run_case(3, 9'd20, 1'b0, 1'b0, lat);
        check_case("over", 16, 1'b1, 1'b0, 22, lat);

        // {1,2}: incomplete tree
        lv = '{1, 2, 0, 0, 0, 0, 0, 0};
        en = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, -1, -1, -1, -1};
        er = '{0, 1, 0, -1, 0, 1, 0, -1, 0, 1, 0, -1, 0, 1, 0, -1};
        run_case(2, 9'd40, 1'b0, 1'b0, lat);
        check_case("incomp", 12, 1'b0, 1'b1, 28, lat);

        // sym_num = 0 and an all-zero scan: no writes
        for (int a = 0; a < 16; a++) begin en[a] = -1; er[a] = -1; end
        lv = '{0, 0, 0, 0, 0, 0, 0, 0};
        run_case(0, 9'd60, 1'b0, 1'b0, lat);
        check_case("empty", 0, 1'b0, 1'b1, 0, lat);
        run_case(2, 9'd60, 1'b0, 1'b0, lat);
        check_case("zeros", 0, 1'b0, 1'b1, 16, lat);

        // {1,5}: length beyond MAX_LEN
        lv = '{1, 5, 0, 0, 0, 0, 0, 0};
        en = '{0, 0, 0, 0, 0, 0, 0, 0, -1, -1, -1, -1, -1, -1, -1, -1};
        er = '{0, -1, 0, -1, 0, -1, 0, -1, 0, -1, 0, -1, 0, -1, 0, -1};
        run_case(2, 9'd80, 1'b0, 1'b0, lat);
        check_case("toolong", 8, 1'b1, 1'b0, 12, lat);

        // {1,1} under alternating write backpressure
        lv = '{1, 1, 0, 0, 0, 0, 0, 0};
        en = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        er = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
        run_case(2, 9'd100, 1'b1, 1'b0, lat);
        check_case("bp", 16, 1'b0, 1'b0, -1, lat);

        // Reset while filling, then a clean rerun of {2,1,3,3} with a stray start while busy
        lv = '{2, 1, 3, 3, 0, 0, 0, 0};
        set_lens(9'd510, 4);
        sym_num = 9'd4; len_base = 9'd510;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 200 && !wr_en0; c++) @(negedge clk);
        chk("rst_fill_reached", 32'(wr_en0), 32'd1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("midrst wr_en", 32'(wr_en0), 32'd0);
        chk("midrst wr_en_rev", 32'(wr_en1), 32'd0);
        chk("midrst busy", 32'(busy0), 32'd0);
        chk("midrst len_addr", 32'(len_addr0), 32'd0);
        chk("midrst wr_addr", 32'(wr_addr0), 32'd0);
        chk("midrst wr_sym", 32'(wr_sym0), 32'd0);
        chk("midrst wr_len", 32'(wr_len0), 32'd0);
        w = wcnt0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst no_writes", 32'(wcnt0), 32'(w));
        en = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 2, 2, 3, 3};
        er = '{1, 0, 1, 2, 1, 0, 1, 3, 1, 0, 1, 2, 1, 0, 1, 3};
        run_case(4, 9'd510, 1'b0, 1'b1, lat);
        check_case("rerun", 16, 1'b0, 1'b0, 48, lat);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
